// File: rtl/toggle_period_meter_if.sv
// Result handshake between the toggle period meter and its consumer.
// The producer drives result and status; the consumer drives meas_ready.
interface toggle_period_meter_if #(
  parameter int WIDTH = 16
);
  logic             meas_valid;
  logic             meas_ready;
  logic [WIDTH-1:0] half_period_ms;
  logic             overrun;
  logic             timeout;

  modport master (
    output meas_valid,
    output half_period_ms,
    output overrun,
    output timeout,
    input  meas_ready
  );

  modport slave (
    input  meas_valid,
    input  half_period_ms,
    input  overrun,
    input  timeout,
    output meas_ready
  );
endinterface

// File: rtl/toggle_period_meter.sv
// Measures the time between level changes of an asynchronous input and
// reports each half-period in whole milliseconds over a valid/ready handshake.
module toggle_period_meter #(
  parameter int CLKS_PER_MS = 100_000,
  parameter int WIDTH       = 16,
  parameter int TIMEOUT_MS  = 65535
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   sig_in,
  toggle_period_meter_if.master  meas
);
  localparam int PW = (CLKS_PER_MS > 2) ? $clog2(CLKS_PER_MS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EDGE,
    MEASURE
  } state_t;

  state_t           state;
  logic [1:0]       sync;
  logic             dly;
  logic             sig_edge;
  logic [PW-1:0]    pre_cnt;
  logic [WIDTH-1:0] ms_cnt;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             overrun_q;
  logic             timeout_q;
  logic             accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      dly  <= 1'b0;
    end else begin
      sync <= {sync[0], sig_in};
      dly  <= sync[1];
    end
  end

  assign sig_edge = sync[1] ^ dly;
  assign accept   = valid_q & meas.meas_ready;

  // The edge cycle itself counts as the first clock of the new interval,
  // so the prescaler restarts at 1 and ms_cnt equals floor(N / CLKS_PER_MS).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      ms_cnt    <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else if (!enable) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      ms_cnt    <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (accept) valid_q <= 1'b0;
      case (state)
        IDLE: state <= WAIT_EDGE;
        WAIT_EDGE: begin
          if (sig_edge) begin
            state   <= MEASURE;
            pre_cnt <= PW'(1);
            ms_cnt  <= '0;
          end
        end
        MEASURE: begin
          if (sig_edge) begin
            data_q  <= ms_cnt;
            valid_q <= 1'b1;
            if (valid_q && !meas.meas_ready) overrun_q <= 1'b1;
            pre_cnt <= PW'(1);
            ms_cnt  <= '0;
          end else if (pre_cnt == PW'(CLKS_PER_MS - 1)) begin
            if (ms_cnt == WIDTH'(TIMEOUT_MS - 1)) begin
              timeout_q <= 1'b1;
              state     <= WAIT_EDGE;
              pre_cnt   <= '0;
              ms_cnt    <= '0;
            end else begin
              pre_cnt <= '0;
              ms_cnt  <= ms_cnt + 1'b1;
            end
          end else begin
            pre_cnt <= pre_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign meas.meas_valid     = valid_q;
  assign meas.half_period_ms = data_q;
  assign meas.overrun        = overrun_q;
  assign meas.timeout        = timeout_q;
endmodule

// File: doc/toggle_period_meter.md
# toggle_period_meter

Measures the time between successive level changes of an asynchronous toggling input (e.g. a blinking LED/heartbeat line driven by the millisecond timer) and reports each half-period in whole milliseconds. It is the receiving end of the timer's toggle output: the timer converts a ms count into toggles, this block converts toggles back into a ms count. It sits in the peripheral space next to the timer and hands results to the core through a valid/ready handshake.

## Interface
- CLKS_PER_MS, 100_000: clock cycles per millisecond tick (100 MHz clock); legal range ≥ 2.
- WIDTH, 16: width of the ms result and counter.
- TIMEOUT_MS, 65535: ms without an edge before a timeout is declared; legal range 1..2^WIDTH-1.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  measurement enable; low clears state and flags.
- sig_in  in  1  asynchronous toggling input.
- meas_ready  in  1  consumer accepts result.
- meas_valid  out  1  result held on half_period_ms.
- half_period_ms  out  WIDTH  completed ms between the last two edges.
- overrun  out  1  sticky: a result was overwritten before acceptance.
- timeout  out  1  one-cycle pulse when TIMEOUT_MS elapses without an edge.

## Operation
- sig_in passes through a 2-FF synchronizer, then a delay FF; edge = sync XOR delayed, so both rising and falling edges count.
- Prescaler counts 0..CLKS_PER_MS-1 and wraps, producing a ms tick; ms counter increments on each tick. An edge in WAIT_EDGE or MEASURE restarts both, so the next sample covers the new interval.
- For edges detected at cycles t0 and t1, N = t1 - t0 and the result is floor(N / CLKS_PER_MS).
- FSM:
  - IDLE: entered on reset or whenever enable is low; counters, meas_valid, overrun and timeout are cleared. Goes to WAIT_EDGE when enable = 1.
  - WAIT_EDGE: the first edge produces no result; go to MEASURE with counters restarted.
  - MEASURE: on an edge, load half_period_ms with the ms count, set meas_valid, restart counters, and stay in MEASURE. When the ms count reaches TIMEOUT_MS without an edge, pulse timeout for one cycle, go to WAIT_EDGE, and leave the published result and valid untouched.
- Handshake: meas_valid holds until a cycle with meas_valid = 1 and meas_ready = 1. half_period_ms stays stable while valid = 1, unless it is overwritten.
- New result while valid = 1 and ready = 0: overwrite half_period_ms, keep valid = 1, set overrun. overrun is cleared only by reset or enable low.
- New result in the same cycle as an accept: valid stays 1 with the new data; no overrun.
- Counter never wraps: TIMEOUT_MS ≤ 2^WIDTH-1 bounds it.
- enable low mid-measurement: abort immediately and discard the partial count; nothing is published.

## Timing
- Reset values: meas_valid 0, half_period_ms 0, overrun 0, timeout 0, state IDLE, all counters 0.
- sig_in change first sampled at clock edge k: edge is detected during the cycle after k+1, and meas_valid / half_period_ms update at edge k+2.
- Accept at edge j (valid and ready both high): meas_valid is 0 after edge j unless a new result lands at j.
- timeout is asserted for exactly one cycle, at the edge where the ms count reaches TIMEOUT_MS.
- enable falling: all outputs are cleared at the next clock edge. reset_n low clears them asynchronously.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Bench parameters: CLKS_PER_MS = 10, TIMEOUT_MS = 20, WIDTH = 16.
- Reset: reset_n low with sig_in toggling -> all outputs 0. Release with enable = 0 -> outputs stay 0, state IDLE.
- Toggle sig_in every 50 clocks, meas_ready = 1 -> no result for the first edge. Each later edge gives a one-cycle meas_valid with half_period_ms = 5, 3 clocks after the change.
- Period 57 clocks -> 5. Period 9 clocks -> 0. Period 10 clocks -> 1 (floor boundary).
- meas_ready = 0, two edges at 30 clocks then 70 clocks -> valid held, data 3 then 7, overrun = 1. Ready high -> valid drops the next cycle, overrun stays 1. Accept coincident with a new result -> valid stays 1 with new data.
- Hold sig_in constant 300 clocks after a measurement -> timeout pulse at exactly 200 clocks after the last edge, prior result unchanged. Next edge gives no result; the following edge publishes normally.
- enable low mid-interval, and separately reset_n pulse mid-interval -> flags and valid clear (next edge / asynchronously). After re-enable, the first edge produces no result.
